lc3_trace_buffer: RTL
=====================

# lc3_trace_buffer

- Synthesizable, parametrised capture unit for the LC-3 datapath observation points:
  - instruction-fetch (IR load) events
  - completed memory writes
  - completed memory reads
- Stores events as time-stamped records in an on-chip buffer. The testbench or a debug port drains them over a valid/ready stream.
- Sits beside the datapath/memory, tapping the same signals the verification interface observes. Adds configurable depth, stop-or-wrap overflow modes, per-event masking and loss accounting.

## Interface
Parameters:
- DATA_W, 16, width of pc/ir/memory data and address fields
- DEPTH, 16, buffer entries; power of two, ≥2
- TS_W, 16, timestamp width
- CNT_W, 16, width of drop/overflow counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  sync pulse: empty buffer, zero counters (timestamp unaffected)
- capture_en  in  1  global capture enable
- mode  in  1  0 = STOP (drop new when full), 1 = WRAP (overwrite oldest)
- event_mask  in  3  bit0 INSTR, bit1 MWR, bit2 MRD; 1 = capture
- ld_ir, pc_obs[DATA_W], ir_obs[DATA_W]  in  instruction event source
- mem_we, mem_re, mem_ready  in  1 each  memory strobes
- mem_addr, mem_wdata, mem_rdata  in  DATA_W each  memory fields
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_kind  out  2  1 INSTR, 2 MWR, 3 MRD
- out_ts  out  TS_W  capture timestamp
- out_addr, out_data  out  DATA_W each  record fields
- count  out  $clog2(DEPTH)+1  entries held
- full, empty  out  1 each
- drop_cnt, ovf_cnt  out  CNT_W each  saturating loss counters

## Operation
- Event qualification, sampled each rising clk while capture_en=1:
  - INSTR: ld_ir=1 → addr=pc_obs, data=ir_obs.
  - MWR: mem_we & mem_ready → addr=mem_addr, data=mem_wdata.
  - MRD: mem_re & mem_ready → addr=mem_addr, data=mem_rdata.
  - Masked events are ignored entirely and are not counted.
- At most one record is written per cycle. Priority is INSTR > MWR > MRD. Each losing unmasked event increments drop_cnt.
- Timestamp is a free-running TS_W counter: 0 after reset, +1 per cycle, wraps.
- Pop: out_valid & out_ready removes the oldest entry.
- Full, STOP mode: a push without a simultaneous pop is discarded, ovf_cnt+1.
- Full, WRAP mode: a push without a simultaneous pop overwrites the oldest entry, the read pointer advances, ovf_cnt+1, count stays DEPTH. out_* may change while out_valid=1 and out_ready=0; this is permitted in WRAP only.
- Full with simultaneous push and pop (either mode): both succeed, count unchanged, no overflow.
- Pop when empty: no effect.
- drop_cnt and ovf_cnt saturate at all-ones.
- clear has priority over same-cycle push/pop. Both pointers and both counters go to 0, and the event in the clear cycle is not captured.

## Timing
- Reset values:
  - out_valid=0, empty=1, full=0, count=0, drop_cnt=0, ovf_cnt=0.
  - out_kind/out_ts/out_addr/out_data=0.
  - Internal timestamp=0.
- Latency: an event sampled at edge N appears on out_* with out_valid=1 after edge N (cycle N+1) when the buffer was empty.
- out_* are driven combinationally from the entry at the read pointer; zero when empty.
- count/full/empty update on the same edge as the push/pop.
- Reset mid-capture discards all contents; no partial record survives.

## Structure
- Package lc3_trace_pkg:
  - trace_kind_e (NONE=0, INSTR=1, MWR=2, MRD=3)
  - trace_mode_e (STOP=0, WRAP=1)
  - KIND_W=2
- Record width = KIND_W+TS_W+2·DATA_W, computed locally.
- One sub-module, lc3_trace_ram: DEPTH×record storage with synchronous write and asynchronous read.
- Pointers, counters and qualification logic live in the top.

## Test plan
- Reset, then ld_ir=1 with pc_obs=0x3000, ir_obs=0x1261 at edge 5 → next cycle out_valid=1, kind=1, addr=0x3000, data=0x1261, ts=5, count=1.
- Same cycle: ld_ir=1 and mem_we&mem_ready with addr=0x4000 → only the INSTR record is stored, drop_cnt=1.
- DEPTH=4, STOP, out_ready=0, 6 MWR events with data 1..6 → count=4, full=1, ovf_cnt=2, drained data 1,2,3,4.
- DEPTH=4, WRAP, same stimulus → ovf_cnt=2, drained data 3,4,5,6.
- Full with push and pop in the same cycle → count stays 4, ovf_cnt unchanged, popped oldest and new entry last.
- event_mask=3'b011, MRD with rdata=0xBEEF → nothing stored, drop_cnt=0. Then clear mid-stream → count=0, empty=1, counters 0, timestamp keeps running.

Source files
------------

// File: rtl/lc3_trace_buffer_pkg.sv
// Shared types for the LC-3 trace capture unit: record kinds, overflow modes
// and the kind field width.
package lc3_trace_pkg;

  localparam int KIND_W = 2;

  typedef enum logic [KIND_W-1:0] {
    NONE  = 2'd0,
    INSTR = 2'd1,
    MWR   = 2'd2,
    MRD   = 2'd3
  } trace_kind_e;

  typedef enum logic {
    STOP = 1'b0,
    WRAP = 1'b1
  } trace_mode_e;

endpackage

// File: rtl/lc3_trace_buffer_if.sv
// Record drain stream: the trace buffer is the master, the consumer (debug
// port or testbench) is the slave.
interface lc3_trace_if
  import lc3_trace_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TS_W   = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [KIND_W-1:0] out_kind;
  logic [TS_W-1:0]   out_ts;
  logic [DATA_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, out_kind, out_ts, out_addr, out_data,
                  input  out_ready);
  modport slave  (input  out_valid, out_kind, out_ts, out_addr, out_data,
                  output out_ready);
endinterface

// File: rtl/lc3_trace_buffer_ram.sv
// Record storage: synchronous write, asynchronous read. No reset; validity of
// entries is tracked by the pointers in the top.
module lc3_trace_ram #(
  parameter int DEPTH = 16,
  parameter int REC_W = 50
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [REC_W-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [REC_W-1:0]         rdata
);
  logic [REC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/lc3_trace_buffer.sv
// LC-3 datapath trace capture: qualifies IR-load and memory events, stores
// time-stamped records in a circular buffer and drains them over a stream.
module lc3_trace_buffer
  import lc3_trace_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   capture_en,
  input  logic                   mode,
  input  logic [2:0]             event_mask,
  input  logic                   ld_ir,
  input  logic [DATA_W-1:0]      pc_obs,
  input  logic [DATA_W-1:0]      ir_obs,
  input  logic                   mem_we,
  input  logic                   mem_re,
  input  logic                   mem_ready,
  input  logic [DATA_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  lc3_trace_if.master            out_if,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       ovf_cnt
);
  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = KIND_W + TS_W + 2 * DATA_W;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] drop_q, drop_d, ovf_q, ovf_d;

  logic              ev_instr, ev_mwr, ev_mrd, push_req, pop;
  logic              push_ok, wrap_ow, ram_we;
  logic [1:0]        n_ev, n_lost;
  logic [CNT_W:0]    drop_sum;
  trace_kind_e       rec_kind;
  logic [DATA_W-1:0] rec_addr, rec_data;
  logic [REC_W-1:0]  ram_rdata;
  logic [KIND_W-1:0] rd_kind;
  logic [TS_W-1:0]   rd_ts;
  logic [DATA_W-1:0] rd_addr, rd_data;

  assign ev_instr = capture_en & event_mask[0] & ld_ir;
  assign ev_mwr   = capture_en & event_mask[1] & mem_we & mem_ready;
  assign ev_mrd   = capture_en & event_mask[2] & mem_re & mem_ready;
  assign push_req = ev_instr | ev_mwr | ev_mrd;
  assign n_ev     = {1'b0, ev_instr} + {1'b0, ev_mwr} + {1'b0, ev_mrd};
  assign n_lost   = (n_ev == 2'd0) ? 2'd0 : n_ev - 2'd1;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW + 1)'(DEPTH));
  assign count = count_q;
  assign pop   = ~empty & out_if.out_ready;

  // A full buffer still accepts a push when the same cycle pops.
  assign push_ok = push_req & (~full | pop);
  assign wrap_ow = push_req & full & ~pop & (trace_mode_e'(mode) == WRAP);
  assign ram_we  = ~clear & (push_ok | wrap_ow);

  always_comb begin
    rec_kind = MRD;
    rec_addr = mem_addr;
    rec_data = mem_rdata;
    if (ev_instr) begin
      rec_kind = INSTR;
      rec_addr = pc_obs;
      rec_data = ir_obs;
    end else if (ev_mwr) begin
      rec_kind = MWR;
      rec_data = mem_wdata;
    end
  end

  always_comb begin
    ts_d     = ts_q + TS_W'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    drop_sum = {1'b0, drop_q} + {{(CNT_W - 1){1'b0}}, n_lost};
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_d   = '0;
      ovf_d    = '0;
    end else begin
      if (push_ok || wrap_ow) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop || wrap_ow)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop)    count_d  = count_q + (AW + 1)'(1);
      else if (!push_ok && pop) count_d = count_q - (AW + 1)'(1);
      drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      if (push_req && full && !pop && ovf_q != '1) ovf_d = ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ts_q     <= '0;
      drop_q   <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ts_q     <= ts_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  lc3_trace_ram #(.DEPTH(DEPTH), .REC_W(REC_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata ({rec_kind, ts_q, rec_addr, rec_data}),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign {rd_kind, rd_ts, rd_addr, rd_data} = ram_rdata;

  assign out_if.out_valid = ~empty;
  assign out_if.out_kind  = empty ? '0 : rd_kind;
  assign out_if.out_ts    = empty ? '0 : rd_ts;
  assign out_if.out_addr  = empty ? '0 : rd_addr;
  assign out_if.out_data  = empty ? '0 : rd_data;
  assign drop_cnt = drop_q;
  assign ovf_cnt  = ovf_q;
endmodule
